// File: rtl/led_fade_pkg.sv
// led_fade_pkg: shared constants, types and helpers for the LED fade/PWM stage.
//
// Contents:
//   PWM_BITS_DEF - default PWM counter / brightness width.
//   bright_t     - brightness type at the default width.
//   bright_max() - full-scale brightness for a given width (2^bits - 1).
//   sat_sub()    - subtraction that floors at zero instead of wrapping.
package led_fade_pkg;

  localparam int unsigned PWM_BITS_DEF = 8;

  typedef logic [PWM_BITS_DEF-1:0] bright_t;

  function automatic int unsigned bright_max(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

  // Decay must stop at off; a wrap would flash a dark LED back to full.
  function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

endpackage

// File: rtl/led_fade_pwm_channel.sv
// led_pwm_channel: one LED channel of the fade/PWM stage.
//
// Holds the live brightness (loaded to full on a pattern hit, decremented on
// each decay tick), a shadow copy that only updates at the PWM period boundary
// so the duty cycle never changes mid-period, and the registered PWM compare.
//
// Build option: define LED_FADE_GAMMA_EN to square the brightness (gamma-2
// approximation) when it is copied into the shadow register.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   pwm_cnt    in   shared PWM counter
//   period_end in   high while pwm_cnt is at its last value
//   decay_tick in   one-cycle decay strobe from the shared prescaler
//   load       in   pattern hit for this channel (valid strobe and bit set)
//   led        out  registered PWM output
module led_pwm_channel
  import led_fade_pkg::*;
#(
  parameter int unsigned PWM_BITS   = PWM_BITS_DEF,
  parameter int unsigned DECAY_STEP = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                period_end,
  input  logic                decay_tick,
  input  logic                load,
  output logic                led
);

  localparam logic [PWM_BITS-1:0] BrightMax = PWM_BITS'(bright_max(PWM_BITS));

  logic [PWM_BITS-1:0] bright_q, bright_d;
  logic [PWM_BITS-1:0] shadow_q, shadow_d;
  logic [PWM_BITS-1:0] shadow_val;
  logic                led_q, led_d;

  // Load has priority over a coincident decay tick.
  always_comb begin
    bright_d = bright_q;
    if (load) begin
      bright_d = BrightMax;
    end else if (decay_tick) begin
      bright_d = PWM_BITS'(sat_sub(32'(bright_q), DECAY_STEP));
    end
  end

`ifdef LED_FADE_GAMMA_EN
  // Upper half of the full-width square: max -> max-1, small values -> 0.
  assign shadow_val = PWM_BITS'(((2 * PWM_BITS)'(bright_q) * (2 * PWM_BITS)'(bright_q))
                                >> PWM_BITS);
`else
  assign shadow_val = bright_q;
`endif

  always_comb begin
    shadow_d = shadow_q;
    if (period_end) begin
      shadow_d = shadow_val;
    end
  end

  // Strict compare: shadow == max still drops low for the final count.
  always_comb begin
    led_d = (shadow_q > pwm_cnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bright_q <= '0;
      shadow_q <= '0;
      led_q    <= 1'b0;
    end else begin
      bright_q <= bright_d;
      shadow_q <= shadow_d;
      led_q    <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/led_fade_pwm.sv
// led_fade_pwm: comet-tail LED driver fed by the rotating pattern generator.
//
// Every LED whose pattern bit is set on a valid strobe jumps to full
// brightness and then fades linearly to off. Brightness is rendered as PWM
// with a period of 2^PWM_BITS clocks; duty changes only at period boundaries.
//
// Build option: LED_FADE_GAMMA_EN selects gamma-2 shaped duty (see channel).
//
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   pattern_in    in   LED pattern, bit i drives channel i
//   pattern_valid in   single-cycle strobe qualifying pattern_in
//   led_out       out  registered PWM outputs to the LED pins
//   frame_sync    out  one-cycle pulse as the PWM counter wraps to 0
module led_fade_pwm
  import led_fade_pkg::*;
#(
  parameter int unsigned N_LEDS      = 5,
  parameter int unsigned PWM_BITS    = PWM_BITS_DEF,
  parameter int unsigned DECAY_SHIFT = 16,
  parameter int unsigned DECAY_STEP  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_LEDS-1:0] pattern_in,
  input  logic              pattern_valid,
  output logic [N_LEDS-1:0] led_out,
  output logic              frame_sync
);

  logic [PWM_BITS-1:0]    pwm_cnt_q, pwm_cnt_d;
  logic [DECAY_SHIFT-1:0] presc_q, presc_d;
  logic                   frame_sync_q, frame_sync_d;
  logic                   period_end;
  logic                   decay_tick;

  assign period_end = (pwm_cnt_q == '1);
  assign decay_tick = (presc_q == '1);

  always_comb begin
    pwm_cnt_d    = pwm_cnt_q + PWM_BITS'(1);
    presc_d      = presc_q + DECAY_SHIFT'(1);
    frame_sync_d = period_end;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q    <= '0;
      presc_q      <= '0;
      frame_sync_q <= 1'b0;
    end else begin
      pwm_cnt_q    <= pwm_cnt_d;
      presc_q      <= presc_d;
      frame_sync_q <= frame_sync_d;
    end
  end

  assign frame_sync = frame_sync_q;

  for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
    led_pwm_channel #(
      .PWM_BITS  (PWM_BITS),
      .DECAY_STEP(DECAY_STEP)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .pwm_cnt   (pwm_cnt_q),
      .period_end(period_end),
      .decay_tick(decay_tick),
      .load      (pattern_valid & pattern_in[i]),
      .led       (led_out[i])
    );
  end

endmodule

// File: tb/tb_led_fade_pwm.sv
// Directed bench for led_fade_pwm with DECAY_SHIFT=4, DECAY_STEP=16, PWM_BITS=8.
// The PWM counter and decay prescaler both restart at reset release, so the
// bench's own post-reset cycle count fixes where period boundaries and decay
// ticks fall; all expected values below are derived from that count by hand.
module tb_led_fade_pwm;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] pattern_in = '0;
  logic         pattern_valid = 1'b0;
  logic [N-1:0] led_out;
  logic         frame_sync;

  int          vectors = 0;
  int          miscompares = 0;
  int unsigned cyc;
  int          hi_cnt[N];

  led_fade_pwm #(
    .N_LEDS     (N),
    .PWM_BITS   (8),
    .DECAY_SHIFT(4),
    .DECAY_STEP (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pattern_in   (pattern_in),
    .pattern_valid(pattern_valid),
    .led_out      (led_out),
    .frame_sync   (frame_sync)
  );

  always #5 clk = ~clk;

  // Posedges since reset release == value of the DUT PWM counter (mod 256).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic int gam(input int x);
`ifdef LED_FADE_GAMMA_EN
    return (x * x) >> 8;
`else
    return x;
`endif
  endfunction

  task automatic wait_sync(input string name);
    int n = 0;
    while (frame_sync !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (frame_sync !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: frame_sync timeout, got %b want 1", name, frame_sync);
    end
  endtask

  // Counts high samples over the 256 clocks following a frame_sync.
  task automatic measure(input string name, input int e0, input int e1, input int e2,
                         input int e3, input int e4);
    int exp_c[N];
    exp_c[0] = e0; exp_c[1] = e1; exp_c[2] = e2; exp_c[3] = e3; exp_c[4] = e4;
    wait_sync(name);
    for (int i = 0; i < N; i++) hi_cnt[i] = 0;
    repeat (256) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (led_out[i] === 1'b1) hi_cnt[i]++;
    end
    for (int i = 0; i < N; i++) begin
      vectors++;
      if (hi_cnt[i] != exp_c[i]) begin
        miscompares++;
        $display("FAIL %s ch%0d: high-time %0d, expected %0d", name, i, hi_cnt[i], exp_c[i]);
      end
    end
  endtask

  // Presents pat on the edge where the PWM counter equals p.
  task automatic strobe_at(input int unsigned p, input logic [N-1:0] pat);
    int n = 0;
    while ((cyc % 256) != p && n < 600) begin
      @(negedge clk);
      n++;
    end
    pattern_in    = pat;
    pattern_valid = 1'b1;
    @(negedge clk);
    pattern_valid = 1'b0;
    pattern_in    = '0;
  endtask

  task automatic check_idle(input string name, input int cycles);
    logic exp_fs;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      exp_fs = (cyc != 0) && (cyc % 256 == 0);
      vectors++;
      if (led_out !== '0) begin
        miscompares++;
        $display("FAIL %s led_out @%0d: got %b want 0", name, cyc, led_out);
      end
      vectors++;
      if (frame_sync !== exp_fs) begin
        miscompares++;
        $display("FAIL %s frame_sync @%0d: got %b want %b", name, cyc, frame_sync, exp_fs);
      end
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (led_out !== '0 || frame_sync !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: led_out=%b frame_sync=%b want 0/0", led_out, frame_sync);
    end
    rst_n = 1'b1;
    check_idle("idle", 1024);
  endtask

  task automatic test_load_full();
    int n = 0;
    strobe_at(245, 5'b00001);
    while (frame_sync !== 1'b1 && n < 600) begin
      vectors++;
      if (led_out !== '0) begin
        miscompares++;
        $display("FAIL pre_boundary: led_out=%b want 0", led_out);
      end
      @(negedge clk);
      n++;
    end
    measure("full_period", gam(255), 0, 0, 0, 0);
    measure("after_full", 0, 0, 0, 0, 0);
  endtask

  task automatic test_decay();
    int          exp_b;
    int unsigned p;
    strobe_at(100, 5'b00001);
    exp_b = 255;
    vectors++;
    if (dut.g_ch[0].u_ch.bright_q !== 8'(exp_b)) begin
      miscompares++;
      $display("FAIL decay_load: bright0=%0d want %0d", dut.g_ch[0].u_ch.bright_q, exp_b);
    end
    repeat (155) begin
      @(negedge clk);
      p = (cyc - 1) % 256;
      if (p % 16 == 15) exp_b = (exp_b > 16) ? exp_b - 16 : 0;
      vectors++;
      if (dut.g_ch[0].u_ch.bright_q !== 8'(exp_b)) begin
        miscompares++;
        $display("FAIL decay_step @p%0d: bright0=%0d want %0d", p,
                 dut.g_ch[0].u_ch.bright_q, exp_b);
      end
    end
    measure("decay_shadow", gam(111), 0, 0, 0, 0);
    vectors++;
    if (dut.g_ch[0].u_ch.bright_q !== 8'd0) begin
      miscompares++;
      $display("FAIL decay_floor: bright0=%0d want 0", dut.g_ch[0].u_ch.bright_q);
    end
    measure("decay_off", 0, 0, 0, 0, 0);
    vectors++;
    if (dut.g_ch[0].u_ch.bright_q !== 8'd0) begin
      miscompares++;
      $display("FAIL no_wrap: bright0=%0d want 0", dut.g_ch[0].u_ch.bright_q);
    end
  endtask

  task automatic test_load_vs_decay();
    int n = 0;
    strobe_at(0, 5'b00011);
    while ((cyc % 256) != 159 && n < 600) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (dut.g_ch[1].u_ch.bright_q !== 8'd111) begin
      miscompares++;
      $display("FAIL pre_tick: bright1=%0d want 111", dut.g_ch[1].u_ch.bright_q);
    end
    strobe_at(159, 5'b00010);
    vectors++;
    if (dut.g_ch[1].u_ch.bright_q !== 8'd255) begin
      miscompares++;
      $display("FAIL load_wins: bright1=%0d want 255", dut.g_ch[1].u_ch.bright_q);
    end
    vectors++;
    if (dut.g_ch[0].u_ch.bright_q !== 8'd95) begin
      miscompares++;
      $display("FAIL other_decays: bright0=%0d want 95", dut.g_ch[0].u_ch.bright_q);
    end
    measure("load_vs_decay", gam(15), gam(175), 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    strobe_at(245, 5'b00001);
    wait_sync("mid_sync");
    repeat (10) @(negedge clk);
    vectors++;
    if (led_out[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_on: led_out[0]=%b want 1", led_out[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (led_out !== '0 || frame_sync !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: led_out=%b frame_sync=%b want 0/0", led_out, frame_sync);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_idle("post_reset", 600);
  endtask

  task automatic test_gamma();
    strobe_at(245, 5'b00100);
    measure("gamma_full", 0, 0, gam(255), 0, 0);
    strobe_at(100, 5'b00100);
    measure("gamma_mid", 0, 0, gam(111), 0, 0);
  endtask

  initial begin
    test_reset();
    test_load_full();
    test_decay();
    test_load_vs_decay();
    test_reset_mid();
    test_gamma();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
